ps2kb_command_controller: RTL and testbench
===========================================

Name: ps2kb_command_controller

Overview:
- Host-to-device command sequencer for the PS/2 keyboard port.
- Arbitrates two command requesters: keyboard reset and LED update.
- Takes ownership of the PS/2 clock/data lines and serialises command bytes with odd parity.
- Waits for the device 0xFA ACK, which arrives through the existing receive shift path, and retries on timeout; sits beside the keyboard scancode controller and shares its receive path.

Parameters:
- INHIBIT_CYCLES, 16'd3000: clocks the PS/2 clock is held low before request-to-send (≥100 µs).
- BIT_TIMEOUT, 16'd6000: maximum clocks between device clock falling edges during transmit.
- ACK_TIMEOUT, 20'd600000: maximum clocks from line-ACK to a received 0xFA.
- MAX_RETRY, 2'd2: retries per byte after the first attempt.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- device_clock  in  1  raw PS/2 clock line (asynchronous).
- device_data  in  1  raw PS/2 data line (asynchronous).
- device_clock_oe  out  1  1 = drive the PS/2 clock low (open-drain).
- device_data_oe  out  1  1 = drive the PS/2 data low (open-drain).
- req_reset  in  1  pulse: send 0xFF.
- req_leds  in  1  pulse: send 0xED followed by the LED byte.
- leds  in  3  {caps, num, scroll}; sampled on req_leds.
- rx_valid  in  1  one-cycle pulse, a byte was received by the receive path.
- rx_data  in  8  received byte.
- rx_suppress  out  1  1 = receive path must discard rx bytes (not forwarded as keycodes).
- busy  out  1  a command is in progress.
- done  out  1  one-cycle pulse, command completed with all ACKs.
- error  out  1  one-cycle pulse, command abandoned after retries.

Behaviour:
- Reset values: state IDLE; device_clock_oe, device_data_oe, rx_suppress, busy, done, error = 0; pending flags cleared; retry count 0.
- device_clock and device_data pass through 2-flop synchronisers. A falling edge is detected on the synchronised clock, giving 3 cycles of latency.
- Request latching: req_reset and req_leds set sticky pending flags in any state. leds are captured at the req_leds pulse; a later req_leds overwrites the captured value.
- Arbitration in IDLE: reset has priority over leds. A reset command clears pending leds, because the keyboard reset clears the LEDs.
- Command byte sequences:
  - reset: [0xFF].
  - leds: [0xED, {5'b0, leds}].
- States and transitions:
  - IDLE: go to INHIBIT when a request is pending; busy = 1 from the next cycle.
  - INHIBIT: device_clock_oe = 1 for INHIBIT_CYCLES; then go to RTS.
  - RTS: device_data_oe = 1 (start bit 0), release device_clock_oe, go to SHIFT.
  - SHIFT: on each device clock falling edge, present the next bit. Order is d0..d7, then odd parity, then stop (data released).
  - Bit encoding: device_data_oe = ~bit.
  - Bit timeout: if BIT_TIMEOUT elapses with no falling edge, go to RETRY.
  - LINE_ACK: after the stop bit, wait for the falling edge with device_data sampled 0.
    - Sampled 1 on that edge, or timeout: RETRY.
    - Sampled 0: WAIT_FA.
  - WAIT_FA:
    - rx_valid with rx_data == 0xFA: advance to the next byte (INHIBIT) or finish (DONE).
    - rx_data == 0xFE (resend): RETRY.
    - Any other byte: ignored.
    - ACK_TIMEOUT elapsed: RETRY.
  - RETRY: if retry count < MAX_RETRY, increment it and restart the same byte at INHIBIT. Otherwise go to FAIL.
  - DONE: done = 1 for one cycle, return to IDLE.
  - FAIL: error = 1 for one cycle, return to IDLE; the remaining bytes of the command are dropped.
- The retry count resets per byte.
- rx_suppress = 1 from INHIBIT through WAIT_FA inclusive. It is 0 in IDLE, DONE and FAIL, so the BAT 0xAA that follows a reset reaches the keycode path.
- Parity bit = ~^byte (odd parity).
- Counters saturate; they never wrap.
- A request that arrives while busy is latched and serviced after DONE or FAIL.
- A simultaneous req_reset and req_leds in IDLE sends reset only.
- Synchronous reset mid-transfer returns all outputs to their reset values immediately, so both lines are released the same cycle.

Decomposition:
- Package ps2kb_pkg:
  - state enum.
  - constants CMD_RESET = 8'hFF, CMD_SET_LEDS = 8'hED, RSP_ACK = 8'hFA, RSP_RESEND = 8'hFE.
- Sub-module ps2kb_tx_shifter: synchroniser, edge detect, 11-bit serialiser, bit timeout, line-ACK capture.
  - Interface: start/byte in, done/fail out.
- The parent module holds arbitration, the byte sequence, WAIT_FA and the retry logic.

Test Plan:
- req_reset, device model clocks bits and returns line-ACK then 0xFA → data sequence 0,1×8,parity 1,stop; done pulses once; busy drops; rx_suppress = 0 afterwards.
- req_leds with leds = 3'b101, both bytes ACKed → bytes 0xED (parity 1) and 0x05 (parity 1) on the wire; exactly one done.
- req_reset and req_leds in the same cycle → only 0xFF is sent; pending leds cleared; done once.
- Device replies 0xFE to the first 0xED → 0xED is resent; success on retry 1; done, no error.
- Device never clocks after RTS → 3 attempts, each ending after BIT_TIMEOUT; error pulse; lines released.
- Reset asserted mid-SHIFT at bit 4 → device_clock_oe, device_data_oe, busy and rx_suppress are 0 on the next cycle; state IDLE.

Source files
------------

// File: rtl/ps2kb_pkg.sv
// Shared types and protocol constants for the PS/2 keyboard command controller
// and its transmit shifter.
package ps2kb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_FA,
    ST_RETRY,
    ST_DONE,
    ST_FAIL
  } ctl_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_INHIBIT,
    TX_RTS,
    TX_SHIFT,
    TX_LINE_ACK
  } tx_state_t;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2kb_tx_shifter.sv
// Host-to-device PS/2 byte transmitter: line inhibit, request-to-send, 11-bit
// frame serialised on device clock falling edges, and line-ACK capture.
module ps2kb_tx_shifter
  import ps2kb_pkg::*;
#(
  parameter logic [15:0] INHIBIT_CYCLES = 16'd3000,
  parameter logic [15:0] BIT_TIMEOUT    = 16'd6000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       device_clock,
  input  logic       device_data,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       clock_oe,
  output logic       data_oe,
  output logic       done,
  output logic       fail
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  tx_state_t   state, next;
  logic [2:0]  clk_sync;
  logic [1:0]  dat_sync;
  logic [15:0] cnt;
  logic [10:0] frame;
  logic [3:0]  idx;
  logic        fall;
  logic        timeout;
  logic        inhibit_end;

  assign fall        = clk_sync[2] & ~clk_sync[1];
  assign timeout     = (cnt >= BIT_TIMEOUT);
  assign inhibit_end = ({1'b0, cnt} + 17'd1 >= {1'b0, INHIBIT_CYCLES});

  // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[1:0], device_clock};
      dat_sync <= {dat_sync[0], device_data};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= TX_IDLE;
      cnt   <= '0;
    end else begin
      state <= next;
      // Our own inhibit pulls the clock low, so edges only count once the device owns it.
      if (state != next || ((state == TX_SHIFT || state == TX_LINE_ACK) && fall))
        cnt <= '0;
      else
        cnt <= sat_inc(cnt);
    end
  end

  // Frame is {stop, parity, d7..d0, start}; bit 0 is always what is on the wire.
  always_ff @(posedge clock) begin
    if (state == TX_IDLE && start) begin
      frame <= {1'b1, odd_parity(tx_byte), tx_byte, 1'b0};
      idx   <= '0;
    end else if (state == TX_SHIFT && fall) begin
      frame <= {1'b1, frame[10:1]};
      idx   <= idx + 4'd1;
    end
  end

  always_comb begin
    next     = state;
    clock_oe = 1'b0;
    data_oe  = 1'b0;
    done     = 1'b0;
    fail     = 1'b0;
    case (state)
      TX_IDLE: if (start) next = TX_INHIBIT;
      TX_INHIBIT: begin
        clock_oe = 1'b1;
        if (inhibit_end) next = TX_RTS;
      end
      TX_RTS: begin
        data_oe = 1'b1;
        next    = TX_SHIFT;
      end
      TX_SHIFT: begin
        data_oe = ~frame[0];
        if (fall && idx == 4'd9) begin
          next = TX_LINE_ACK;
        end else if (!fall && timeout) begin
          fail = 1'b1;
          next = TX_IDLE;
        end
      end
      TX_LINE_ACK: begin
        if (fall) begin
          done = ~dat_sync[1];
          fail = dat_sync[1];
          next = TX_IDLE;
        end else if (timeout) begin
          fail = 1'b1;
          next = TX_IDLE;
        end
      end
      default: next = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/ps2kb_command_controller.sv
// PS/2 keyboard command sequencer: arbitrates reset/LED requests, sends the
// command bytes, waits for the 0xFA acknowledge and retries on failure.
module ps2kb_command_controller
  import ps2kb_pkg::*;
#(
  parameter logic [15:0] INHIBIT_CYCLES = 16'd3000,
  parameter logic [15:0] BIT_TIMEOUT    = 16'd6000,
  parameter logic [19:0] ACK_TIMEOUT    = 20'd600000,
  parameter logic [1:0]  MAX_RETRY      = 2'd2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       device_clock,
  input  logic       device_data,
  output logic       device_clock_oe,
  output logic       device_data_oe,
  input  logic       req_reset,
  input  logic       req_leds,
  input  logic [2:0] leds,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_suppress,
  output logic       busy,
  output logic       done,
  output logic       error
);

  function automatic logic [19:0] sat_inc(input logic [19:0] v);
    return (v == 20'hFFFFF) ? v : v + 20'd1;
  endfunction

  ctl_state_t  state, next;
  logic        pend_reset, pend_leds;
  logic        cmd_is_leds, byte_sel;
  logic [1:0]  retry_cnt;
  logic [19:0] ack_cnt;
  logic [2:0]  led_cap;
  logic [7:0]  cur_byte, tx_byte;
  logic        start, accept, advance, retry_inc;
  logic        tx_done, tx_fail;

  ps2kb_tx_shifter #(
    .INHIBIT_CYCLES(INHIBIT_CYCLES),
    .BIT_TIMEOUT   (BIT_TIMEOUT)
  ) u_tx (
    .clock       (clock),
    .reset       (reset),
    .device_clock(device_clock),
    .device_data (device_data),
    .start       (start),
    .tx_byte     (tx_byte),
    .clock_oe    (device_clock_oe),
    .data_oe     (device_data_oe),
    .done        (tx_done),
    .fail        (tx_fail)
  );

  assign cur_byte = !cmd_is_leds ? CMD_RESET :
                    (byte_sel ? {5'b0, led_cap} : CMD_SET_LEDS);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      pend_reset  <= 1'b0;
      pend_leds   <= 1'b0;
      cmd_is_leds <= 1'b0;
      byte_sel    <= 1'b0;
      retry_cnt   <= '0;
      ack_cnt     <= '0;
    end else begin
      state <= next;
      // A keyboard reset also clears the LEDs, so it swallows any pending LED update.
      if (accept) begin
        cmd_is_leds <= ~pend_reset;
        byte_sel    <= 1'b0;
        retry_cnt   <= '0;
        pend_reset  <= 1'b0;
        pend_leds   <= 1'b0;
      end
      if (req_reset) pend_reset <= 1'b1;
      if (req_leds)  pend_leds  <= 1'b1;
      if (advance) begin
        byte_sel  <= 1'b1;
        retry_cnt <= '0;
      end
      if (retry_inc) retry_cnt <= retry_cnt + 2'd1;
      ack_cnt <= (state == ST_WAIT_FA) ? sat_inc(ack_cnt) : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (req_leds) led_cap <= leds;
  end

  always_comb begin
    next        = state;
    start       = 1'b0;
    tx_byte     = cur_byte;
    accept      = 1'b0;
    advance     = 1'b0;
    retry_inc   = 1'b0;
    busy        = (state != ST_IDLE);
    done        = 1'b0;
    error       = 1'b0;
    rx_suppress = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend_reset || pend_leds) begin
          accept  = 1'b1;
          start   = 1'b1;
          tx_byte = pend_reset ? CMD_RESET : CMD_SET_LEDS;
          next    = ST_SEND;
        end
      end
      ST_SEND: begin
        rx_suppress = 1'b1;
        if (tx_done)      next = ST_WAIT_FA;
        else if (tx_fail) next = ST_RETRY;
      end
      ST_WAIT_FA: begin
        rx_suppress = 1'b1;
        if (rx_valid && rx_data == RSP_ACK) begin
          if (cmd_is_leds && !byte_sel) begin
            advance = 1'b1;
            start   = 1'b1;
            tx_byte = {5'b0, led_cap};
            next    = ST_SEND;
          end else begin
            next = ST_DONE;
          end
        end else if (rx_valid && rx_data == RSP_RESEND) begin
          next = ST_RETRY;
        end else if (ack_cnt >= ACK_TIMEOUT) begin
          next = ST_RETRY;
        end
      end
      ST_RETRY: begin
        rx_suppress = 1'b1;
        if (retry_cnt < MAX_RETRY) begin
          retry_inc = 1'b1;
          start     = 1'b1;
          next      = ST_SEND;
        end else begin
          next = ST_FAIL;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        next = ST_IDLE;
      end
      ST_FAIL: begin
        error = 1'b1;
        next  = ST_IDLE;
      end
      default: next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2kb_command_controller.sv
// Bench for ps2kb_command_controller: a PS/2 device model receives frames and
// replies, comparing each frame against a queue of expected frames.
module tb_ps2kb_command_controller;

  localparam logic [15:0] INH = 16'd20;
  localparam logic [15:0] BTO = 16'd60;
  localparam logic [19:0] ATO = 20'd300;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       device_clock, device_data;
  logic       device_clock_oe, device_data_oe;
  logic       req_reset = 1'b0, req_leds = 1'b0;
  logic [2:0] leds = 3'b000;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_suppress, busy, done, error;

  logic dev_clk = 1'b1, dev_data_low = 1'b0;
  assign device_clock = dev_clk & ~device_clock_oe;
  assign device_data  = ~dev_data_low & ~device_data_oe;

  ps2kb_command_controller #(
    .INHIBIT_CYCLES(INH), .BIT_TIMEOUT(BTO), .ACK_TIMEOUT(ATO), .MAX_RETRY(2'd2)
  ) dut (
    .clock(clock), .reset(reset), .device_clock(device_clock), .device_data(device_data),
    .device_clock_oe(device_clock_oe), .device_data_oe(device_data_oe),
    .req_reset(req_reset), .req_leds(req_leds), .leds(leds),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_suppress(rx_suppress),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int tests = 0, fails = 0;
  int done_cnt = 0, err_cnt = 0, attempts = 0;
  int dev_pulses = 0;
  bit dev_on = 1'b1, dev_abort = 1'b0, dev_in_frame = 1'b0;
  logic prev_coe = 1'b0;
  logic [10:0] exp_frames[$];
  int rsp_q[$];  // -1 means the device stays silent after the line-ACK

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  always @(negedge clock) begin
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (device_clock_oe && !prev_coe) attempts++;
    prev_coe = device_clock_oe;
  end

  // Device model / monitor: clocks in a frame after request-to-send and scores it.
  initial begin : device
    logic [10:0] got;
    logic [10:0] exp;
    int rsp;
    forever begin
      @(negedge clock);
      if (dev_on && !reset && !device_clock_oe && device_data_oe) begin
        dev_in_frame = 1'b1;
        dev_pulses = 0;
        got = '0;
        repeat (5) @(negedge clock);
        got[0] = device_data;
        for (int k = 1; k <= 10; k++) begin
          if (!dev_abort) begin
            dev_clk = 1'b0;
            dev_pulses = k;
            repeat (10) @(negedge clock);
            got[k] = device_data;
            dev_clk = 1'b1;
            repeat (10) @(negedge clock);
          end
        end
        dev_clk = 1'b1;
        if (dev_abort) begin
          if (exp_frames.size() > 0) void'(exp_frames.pop_front());
        end else begin
          dev_data_low = 1'b1;
          repeat (2) @(negedge clock);
          dev_clk = 1'b0;
          repeat (10) @(negedge clock);
          dev_clk = 1'b1;
          repeat (2) @(negedge clock);
          dev_data_low = 1'b0;
          if (exp_frames.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame: got 0x%0h expected none", got);
          end else begin
            exp = exp_frames.pop_front();
            check("frame", 32'(got), 32'(exp));
          end
          rsp = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'hFA;
          if (rsp >= 0) begin
            repeat (10) @(negedge clock);
            rx_data  = rsp[7:0];
            rx_valid = 1'b1;
            @(negedge clock);
            rx_valid = 1'b0;
          end
        end
        dev_in_frame = 1'b0;
      end
    end
  end

  task automatic pulse_req(input logic r, input logic l, input logic [2:0] lv);
    @(negedge clock);
    req_reset = r;
    req_leds  = l;
    leds      = lv;
    @(negedge clock);
    req_reset = 1'b0;
    req_leds  = 1'b0;
  endtask

  task automatic wait_outcome(input string name, input int limit);
    int d0, e0, n;
    d0 = done_cnt;
    e0 = err_cnt;
    n  = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < limit) begin
      @(negedge clock);
      n++;
    end
    if (n >= limit) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done/error expected one within %0d cycles", name, limit);
    end
    repeat (20) @(negedge clock);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  int d0, e0, a0, n;

  initial begin : stim
    repeat (3) @(negedge clock);
    check("rst_clock_oe", 32'(device_clock_oe), 0);
    check("rst_data_oe", 32'(device_data_oe), 0);
    check("rst_rx_suppress", 32'(rx_suppress), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Keyboard reset, ACKed
    d0 = done_cnt; e0 = err_cnt;
    exp_frames.push_back(frame_of(8'hFF));
    rsp_q.push_back(32'hFA);
    pulse_req(1'b1, 1'b0, 3'b000);
    repeat (3) @(negedge clock);
    check("t1_busy_during", 32'(busy), 1);
    check("t1_suppress_during", 32'(rx_suppress), 1);
    wait_outcome("t1", 3000);
    check("t1_done_count", 32'(done_cnt - d0), 1);
    check("t1_error_count", 32'(err_cnt - e0), 0);
    check("t1_busy_after", 32'(busy), 0);
    check("t1_suppress_after", 32'(rx_suppress), 0);

    // LED update 3'b101: two bytes
    d0 = done_cnt; e0 = err_cnt;
    exp_frames.push_back(frame_of(8'hED));
    exp_frames.push_back(frame_of(8'h05));
    rsp_q.push_back(32'hFA);
    rsp_q.push_back(32'hFA);
    pulse_req(1'b0, 1'b1, 3'b101);
    wait_outcome("t2", 3000);
    check("t2_done_count", 32'(done_cnt - d0), 1);
    check("t2_error_count", 32'(err_cnt - e0), 0);
    check("t2_frames_left", 32'(exp_frames.size()), 0);

    // Simultaneous reset and LED requests: reset only
    d0 = done_cnt; e0 = err_cnt;
    exp_frames.push_back(frame_of(8'hFF));
    rsp_q.push_back(32'hFA);
    pulse_req(1'b1, 1'b1, 3'b011);
    wait_outcome("t3", 3000);
    repeat (100) @(negedge clock);
    check("t3_done_count", 32'(done_cnt - d0), 1);
    check("t3_busy_after", 32'(busy), 0);
    check("t3_frames_left", 32'(exp_frames.size()), 0);

    // Resend reply to first 0xED, then success
    d0 = done_cnt; e0 = err_cnt;
    exp_frames.push_back(frame_of(8'hED));
    exp_frames.push_back(frame_of(8'hED));
    exp_frames.push_back(frame_of(8'h05));
    rsp_q.push_back(32'hFE);
    rsp_q.push_back(32'hFA);
    rsp_q.push_back(32'hFA);
    pulse_req(1'b0, 1'b1, 3'b101);
    wait_outcome("t4", 4000);
    check("t4_done_count", 32'(done_cnt - d0), 1);
    check("t4_error_count", 32'(err_cnt - e0), 0);
    check("t4_frames_left", 32'(exp_frames.size()), 0);

    // Silent device: three attempts, each ending on bit timeout
    dev_on = 1'b0;
    d0 = done_cnt; e0 = err_cnt; a0 = attempts;
    pulse_req(1'b1, 1'b0, 3'b000);
    wait_outcome("t5", 2000);
    check("t5_error_count", 32'(err_cnt - e0), 1);
    check("t5_done_count", 32'(done_cnt - d0), 0);
    check("t5_attempts", 32'(attempts - a0), 3);
    check("t5_clock_released", 32'(device_clock_oe), 0);
    check("t5_data_released", 32'(device_data_oe), 0);
    dev_on = 1'b1;

    // Reset mid-shift after the fourth device clock
    exp_frames.push_back(frame_of(8'hFF));
    pulse_req(1'b1, 1'b0, 3'b000);
    n = 0;
    while (dev_pulses != 4 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("t6_reached_bit4", 32'(dev_pulses), 4);
    repeat (5) @(negedge clock);
    dev_abort = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("t6_clock_oe", 32'(device_clock_oe), 0);
    check("t6_data_oe", 32'(device_data_oe), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_suppress", 32'(rx_suppress), 0);
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    while (dev_in_frame && n < 500) begin
      @(negedge clock);
      n++;
    end
    dev_abort = 1'b0;
    repeat (50) @(negedge clock);
    check("t6_idle_after", 32'(busy), 0);
    check("t6_frames_left", 32'(exp_frames.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
